// File: rtl/bcd_pkg.sv
// Shared BCD constants, scan states and an index-width helper
// for the BCD limit-monitor datapath.
package bcd_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    // Minimum of 1 so that single-entry indices still get a bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcd_digit_cmp.sv
// Single-digit BCD magnitude comparator; the one comparison
// resource shared by every channel of the scan sequencer.
module bcd_digit_cmp
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_i,
    input  logic [BCD_W-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             inv_o
);

    assign gt_o  = a_i > b_i;
    assign eq_o  = a_i == b_i;
    assign inv_o = (a_i > BCD_MAX) || (b_i > BCD_MAX);

endmodule

// File: rtl/bcd_scan_sequencer.sv
// Multi-channel BCD limit monitor: snapshots all channels and the limit,
// then compares digit-serially, MSD first, with early exit per channel.
module bcd_scan_sequencer
    import bcd_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [BCD_W*DIGITS-1:0]      limit,
    input  logic [N_CH*BCD_W*DIGITS-1:0] ch_data,
    output logic                         busy,
    output logic                         done,
    output logic [N_CH-1:0]              alarm,
    output logic [N_CH-1:0]              err,
    output logic [clog2(N_CH+1)-1:0]     alarm_cnt
);

    localparam int VW = BCD_W * DIGITS;
    localparam int CW = clog2(N_CH);
    localparam int DW = clog2(DIGITS);
    localparam int NW = clog2(N_CH + 1);

    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
    localparam logic [DW-1:0] MSD     = DW'(DIGITS - 1);

    state_e               state_q;
    logic [CW-1:0]        ch_idx_q;
    logic [DW-1:0]        dig_idx_q;
    logic [VW-1:0]        lim_q;
    logic [N_CH*VW-1:0]   data_q;
    logic [N_CH-1:0]      sh_alarm_q, sh_err_q;
    logic [N_CH-1:0]      alarm_q, err_q;
    logic [NW-1:0]        cnt_q;
    logic                 busy_q, done_q;

    logic [BCD_W-1:0]     dig_a, dig_b;
    logic                 cmp_gt, cmp_eq, cmp_inv;
    logic                 any_inv, resolved, res_err;
    logic [N_CH-1:0]      alarm_d, err_d;
    logic [NW-1:0]        cnt_d;

    always_comb begin
        int base;
        base    = int'(ch_idx_q) * VW;
        dig_a   = data_q[base + int'(dig_idx_q) * BCD_W +: BCD_W];
        dig_b   = lim_q[int'(dig_idx_q) * BCD_W +: BCD_W];
        any_inv = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (data_q[base + d * BCD_W +: BCD_W] > BCD_MAX) any_inv = 1'b1;
            if (lim_q[d * BCD_W +: BCD_W] > BCD_MAX)         any_inv = 1'b1;
        end
    end

    bcd_digit_cmp u_cmp (
        .a_i   (dig_a),
        .b_i   (dig_b),
        .gt_o  (cmp_gt),
        .eq_o  (cmp_eq),
        .inv_o (cmp_inv)
    );

    // Shadow vectors with the current channel's verdict merged in.
    always_comb begin
        resolved          = !cmp_eq || (dig_idx_q == '0);
        res_err           = any_inv | cmp_inv;
        alarm_d           = sh_alarm_q;
        err_d             = sh_err_q;
        alarm_d[ch_idx_q] = cmp_gt & ~res_err;
        err_d[ch_idx_q]   = res_err;
        cnt_d             = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d = cnt_d + NW'(alarm_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_idx_q   <= '0;
            dig_idx_q  <= '0;
            lim_q      <= '0;
            data_q     <= '0;
            sh_alarm_q <= '0;
            sh_err_q   <= '0;
            alarm_q    <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        lim_q      <= limit;
                        data_q     <= ch_data;
                        ch_idx_q   <= '0;
                        dig_idx_q  <= MSD;
                        sh_alarm_q <= '0;
                        sh_err_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= CMP;
                    end
                end
                CMP: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!resolved) begin
                        dig_idx_q <= dig_idx_q - DW'(1);
                    end else if (ch_idx_q != LAST_CH) begin
                        sh_alarm_q <= alarm_d;
                        sh_err_q   <= err_d;
                        ch_idx_q   <= ch_idx_q + CW'(1);
                        dig_idx_q  <= MSD;
                    end else begin
                        alarm_q <= alarm_d;
                        err_q   <= err_d;
                        cnt_q   <= cnt_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign alarm     = alarm_q;
    assign err       = err_q;
    assign alarm_cnt = cnt_q;

endmodule
